mod_rst_seq: RTL and testbench

MOD_RST_SEQ -- requirements
Module: mod_rst_seq

---
 rtl/mod_rst_seq.sv | 101 ++++++++++
 tb/tb_mod_rst_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mod_rst_seq.sv
// PLL lock qualification and reset sequencer: synchronizes i_locked, qualifies it,
// holds o_rst for a minimum width, then releases. Optional lock-loss counter: MOD_RST_SEQ_LOSSCNT_EN.
module mod_rst_seq #(
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  input  logic       i_soft_rst,
  output logic       o_rst,
  output logic       o_ready,
  output logic [1:0] o_state
`ifdef MOD_RST_SEQ_LOSSCNT_EN
  ,
  output logic [7:0] o_loss_cnt
`endif
);

  // state     | meaning
  // WAIT_LOCK | no synchronized lock, reset asserted
  // STABLE    | lock seen, counting consecutive locked cycles
  // HOLD      | lock qualified, reset held for minimum width
  // RUN       | reset released, downstream ready

  localparam int CNT_MAX = (STABLE_CYCLES > RST_HOLD_CYCLES) ? STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;

  assign locked_s = sync[SYNC_STAGES-1];
  assign o_state  = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      WAIT_LOCK: if (locked_s) state_nx = STABLE;
      STABLE: begin
        if (!locked_s)
          state_nx = WAIT_LOCK;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1))
          state_nx = HOLD;
      end
      HOLD: begin
        if (!locked_s)
          state_nx = WAIT_LOCK;
        else if (cnt == CNT_W'(RST_HOLD_CYCLES - 1))
          state_nx = RUN;
      end
      RUN: begin
        // lock loss outranks a simultaneous soft reset request
        if (!locked_s)
          state_nx = WAIT_LOCK;
        else if (i_soft_rst)
          state_nx = HOLD;
      end
      default: state_nx = WAIT_LOCK;
    endcase
    if (state_nx == state && (state == STABLE || state == HOLD))
      cnt_nx = cnt + 1'b1;
  end

  // outputs are registered from the next state so they move on the same edge as the FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync    <= '0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      o_rst   <= 1'b1;
      o_ready <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], i_locked};
      state   <= state_nx;
      cnt     <= cnt_nx;
      o_rst   <= (state_nx != RUN);
      o_ready <= (state_nx == RUN);
    end
  end

`ifdef MOD_RST_SEQ_LOSSCNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_loss_cnt <= '0;
    else if (state == RUN && state_nx == WAIT_LOCK && o_loss_cnt != 8'hFF)
      o_loss_cnt <= o_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mod_rst_seq.sv
// Directed bench for mod_rst_seq with STABLE_CYCLES=8, RST_HOLD_CYCLES=4, SYNC_STAGES=2.
// Lock-loss counter checks are compiled only when MOD_RST_SEQ_LOSSCNT_EN is defined.
module tb_mod_rst_seq;
  logic       clk = 1'b0;
  logic       rst, locked, soft_rst;
  logic       rst_out, ready;
  logic [1:0] state;
`ifdef MOD_RST_SEQ_LOSSCNT_EN
  logic [7:0] loss_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_rst_seq #(.STABLE_CYCLES(8), .RST_HOLD_CYCLES(4), .SYNC_STAGES(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_locked  (locked),
    .i_soft_rst(soft_rst),
    .o_rst     (rst_out),
    .o_ready   (ready),
    .o_state   (state)
`ifdef MOD_RST_SEQ_LOSSCNT_EN
    ,
    .o_loss_cnt(loss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called with the synchronizer cleared and locked already high; the next edge is
  // the first to sample it. Edge k (0-based): STABLE from k=2, HOLD from k=10, RUN at k=14.
  task automatic qualify(input string tag);
    logic [1:0] es;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      es = (k < 2) ? 2'd0 : (k < 10) ? 2'd1 : (k < 14) ? 2'd2 : 2'd3;
      chk({tag, "_state"}, state, es);
      chk({tag, "_ready"}, ready, (k == 14));
      chk({tag, "_rst"}, rst_out, (k != 14));
    end
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; soft_rst = 1'b0;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_orst", rst_out, 1);
    chk("rst_ready", ready, 0);
`ifdef MOD_RST_SEQ_LOSSCNT_EN
    chk("rst_loss", loss_cnt, 0);
`endif
    rst = 1'b0;
    tick(3);
    chk("unlocked_state", state, 0);

    locked = 1'b1;
    qualify("qual");

    // soft reset, plus a second request inside HOLD that must not extend it
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft_s0_state", state, 2);
    chk("soft_s0_rst", rst_out, 1);
    chk("soft_s0_ready", ready, 0);
    tick(1);
    chk("soft_s1_state", state, 2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft_s2_state", state, 2);
    tick(1);
    chk("soft_s3_state", state, 2);
    tick(1);
    chk("soft_s4_state", state, 3);
    chk("soft_s4_ready", ready, 1);
    chk("soft_s4_rst", rst_out, 0);
`ifdef MOD_RST_SEQ_LOSSCNT_EN
    chk("soft_loss", loss_cnt, 0);
`endif

    // lock drop; soft request lands on the edge where the FSM first sees locked_s=0
    locked = 1'b0;
    tick(1);
    chk("loss_d0_state", state, 3);
    tick(1);
    chk("loss_d1_state", state, 3);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("loss_d2_state", state, 0);
    chk("loss_d2_rst", rst_out, 1);
    chk("loss_d2_ready", ready, 0);
`ifdef MOD_RST_SEQ_LOSSCNT_EN
    chk("loss_cnt1", loss_cnt, 1);
`endif

    // glitch after 5 cycles in STABLE restarts qualification
    tick(3);
    locked = 1'b1;
    tick(3);
    chk("gl_stable_state", state, 1);
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    chk("gl_g1_state", state, 1);
    tick(1);
    chk("gl_g2_state", state, 0);
    tick(1);
    chk("gl_f2_state", state, 1);
    tick(11);
    chk("gl_f13_ready", ready, 0);
    chk("gl_f13_state", state, 2);
    tick(1);
    chk("gl_f14_ready", ready, 1);
    chk("gl_f14_state", state, 3);

    // i_rst during HOLD with lock held
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(1);
    chk("hr_hold_state", state, 2);
    rst = 1'b1;
    tick(1);
    chk("hr_state", state, 0);
    chk("hr_rst", rst_out, 1);
    chk("hr_ready", ready, 0);
    rst = 1'b0;
    qualify("hr_requal");

    // i_rst in RUN
    rst = 1'b1;
    tick(1);
    chk("rr_state", state, 0);
    chk("rr_ready", ready, 0);
    chk("rr_rst", rst_out, 1);
`ifdef MOD_RST_SEQ_LOSSCNT_EN
    chk("rr_loss", loss_cnt, 0);
`endif
    rst = 1'b0;
    qualify("rr_requal");

`ifdef MOD_RST_SEQ_LOSSCNT_EN
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      tick(4);
      locked = 1'b1;
      tick(15);
      if (i == 9) chk("sat_loss10", loss_cnt, 10);
    end
    chk("sat_state", state, 3);
    chk("sat_loss", loss_cnt, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
